// File: rtl/hazard_scoreboard_unit.sv
// Latency-aware ID-stage hazard unit: per-register countdown of in-flight producers drives stall/bubble.
// Optional macro HAZARD_STALL_PERF_EN adds stall_cycles / load_use_events performance counters.
module hazard_scoreboard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int ALU_READY  = 1,
  parameter int LOAD_READY = 2,
  parameter int CNT_W      = 2
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  id_valid,
  input  logic                  flush,
  input  logic                  id_branch,
  input  logic                  id_mem_read,
  input  logic                  id_reg_write,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  output logic                  write_if_id_reg,
  output logic                  write_pc,
  output logic                  control_mux,
  output logic                  stall
`ifdef HAZARD_STALL_PERF_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [15:0]           load_use_events
`endif
);

  localparam int NREG = 2 ** REG_ADDR_W;
  localparam logic [CNT_W-1:0] ALU_CNT  = CNT_W'(ALU_READY);
  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_READY);

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [CNT_W-1:0] rs1_cnt_s;
  logic [CNT_W-1:0] rs2_cnt_s;
  logic             haz_rs1_s;
  logic             haz_rs2_s;
  logic             stall_s;
  logic             issue_s;

  // Source hazard detection; a count of 1 is still forwardable to EX unless ID resolves a branch
  always_comb begin
    rs1_cnt_s = cnt_q[id_rs1];
    rs2_cnt_s = cnt_q[id_rs2];
    haz_rs1_s = 1'b0;
    haz_rs2_s = 1'b0;
    if (id_use_rs1 && (id_rs1 != '0)) begin
      if (id_branch) begin
        haz_rs1_s = (rs1_cnt_s > CNT_W'(0));
      end else begin
        haz_rs1_s = (rs1_cnt_s > CNT_W'(1));
      end
    end else begin
      haz_rs1_s = 1'b0;
    end
    if (id_use_rs2 && (id_rs2 != '0)) begin
      if (id_branch) begin
        haz_rs2_s = (rs2_cnt_s > CNT_W'(0));
      end else begin
        haz_rs2_s = (rs2_cnt_s > CNT_W'(1));
      end
    end else begin
      haz_rs2_s = 1'b0;
    end
    stall_s = id_valid & ~flush & (haz_rs1_s | haz_rs2_s);
    issue_s = id_valid & ~flush & ~stall_s;
  end

  // Pipeline enables derived directly from the stall decision
  always_comb begin
    stall           = stall_s;
    write_if_id_reg = ~stall_s;
    write_pc        = ~stall_s;
    control_mux     = ~stall_s;
  end

  // Scoreboard next state: newest producer overwrites, otherwise count down to zero
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (issue_s && id_reg_write && (id_rd == r[REG_ADDR_W-1:0])) begin
        cnt_d[r] = id_mem_read ? LOAD_CNT : ALU_CNT;
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end else begin
        cnt_d[r] = cnt_q[r];
      end
    end
  end

  // Scoreboard state register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
    end
  end

`ifdef HAZARD_STALL_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] load_use_events_q;
  logic        stall_prev_q;

  // Saturating stall-cycle and stall-onset counters
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cycles_q    <= 32'd0;
      load_use_events_q <= 16'd0;
      stall_prev_q      <= 1'b0;
    end else begin
      stall_prev_q <= stall_s;
      if (stall_s && (stall_cycles_q != 32'hFFFF_FFFF)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (stall_s && !stall_prev_q && (load_use_events_q != 16'hFFFF)) begin
        load_use_events_q <= load_use_events_q + 16'd1;
      end
    end
  end

  assign stall_cycles    = stall_cycles_q;
  assign load_use_events = load_use_events_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed self-checking bench for hazard_scoreboard_unit (default and LOAD_READY=4 instances).
module tb_hazard_scoreboard_unit;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       id_valid = 1'b0, flush = 1'b0, id_branch = 1'b0, id_mem_read = 1'b0;
  logic       id_reg_write = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
  logic       wif_a, wpc_a, cmux_a, stall_a;
  logic       wif_b, wpc_b, cmux_b, stall_b;
  int         checks = 0;
  int         errors = 0;
`ifdef HAZARD_STALL_PERF_EN
  logic [31:0] sc_a, sc_b;
  logic [15:0] lue_a, lue_b;
`endif

  always #5 clk = ~clk;

  hazard_scoreboard_unit dut_a (
    .clk(clk), .arst_n(arst_n), .id_valid(id_valid), .flush(flush), .id_branch(id_branch),
    .id_mem_read(id_mem_read), .id_reg_write(id_reg_write), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .write_if_id_reg(wif_a), .write_pc(wpc_a), .control_mux(cmux_a), .stall(stall_a)
`ifdef HAZARD_STALL_PERF_EN
    , .stall_cycles(sc_a), .load_use_events(lue_a)
`endif
  );

  hazard_scoreboard_unit #(.LOAD_READY(4), .CNT_W(3)) dut_b (
    .clk(clk), .arst_n(arst_n), .id_valid(id_valid), .flush(flush), .id_branch(id_branch),
    .id_mem_read(id_mem_read), .id_reg_write(id_reg_write), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .write_if_id_reg(wif_b), .write_pc(wpc_b), .control_mux(cmux_b), .stall(stall_b)
`ifdef HAZARD_STALL_PERF_EN
    , .stall_cycles(sc_b), .load_use_events(lue_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // v fl br mr rw u1 u2 rs1 rs2 rd ; settles combinational outputs before returning
  task automatic drive(input logic v, input logic fl, input logic br, input logic mr,
                       input logic rw, input logic u1, input logic u2,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    id_valid = v; flush = fl; id_branch = br; id_mem_read = mr; id_reg_write = rw;
    id_use_rs1 = u1; id_use_rs2 = u2; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    repeat (n) tick();
  endtask

  initial begin
    // reset state
    #3;
    check("rst_stall", {31'd0, stall_a}, 32'd0);
    check("rst_enables", {29'd0, wif_a, wpc_a, cmux_a}, 32'h7);
    @(negedge clk);
    arst_n = 1'b1;
    tick();
    check("post_rst_stall", {31'd0, stall_a}, 32'd0);

    // load x5, then add x6,x5,x1 : one stall cycle
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5);
    check("ld5_issue_stall", {31'd0, stall_a}, 32'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 5'd1, 5'd6);
    check("ld_use_wpc0", {31'd0, wpc_a}, 32'd0);
    check("ld_use_enables0", {28'd0, stall_a, wif_a, wpc_a, cmux_a}, 32'h8);
    tick();
    check("ld_use_wpc1", {31'd0, wpc_a}, 32'd1);
    tick();
`ifdef HAZARD_STALL_PERF_EN
    check("perf_stall_cycles", sc_a, 32'd1);
    check("perf_events", {16'd0, lue_a}, 32'd1);
`endif
    idle(5);

    // ALU x7 -> beq x7,x0 : one stall
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0);
    check("alu_br_c0", {31'd0, stall_a}, 32'd1);
    tick();
    check("alu_br_c1", {31'd0, stall_a}, 32'd0);
    tick();
    idle(5);

    // load x7 -> beq x7,x0 : two stalls
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0);
    check("ld_br_c0", {31'd0, stall_a}, 32'd1);
    tick();
    check("ld_br_c1", {31'd0, stall_a}, 32'd1);
    tick();
    check("ld_br_c2", {31'd0, stall_a}, 32'd0);
    tick();
    idle(5);

    // ALU x7 -> add x8,x7,x7 : no stall
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 5'd7, 5'd8);
    check("alu_alu_nostall", {31'd0, stall_a}, 32'd0);
    tick();
    idle(5);

    // x0 producer/consumer never stalls, even as a branch
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
    check("x0_nostall", {31'd0, stall_a}, 32'd0);
    tick();
    idle(5);

    // both sources hazarded: load x10, load x11, beq x10,x11 -> released by the slower
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd10);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd11);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd10, 5'd11, 5'd0);
    check("dual_c0", {31'd0, stall_a}, 32'd1);
    tick();
    check("dual_c1", {31'd0, stall_a}, 32'd1);
    tick();
    check("dual_c2", {31'd0, stall_a}, 32'd0);
    tick();
    idle(5);

    // flush suppresses the stall and the scoreboard write of x9
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd12);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd12, 5'd0, 5'd9);
    check("flush_nostall", {31'd0, stall_a}, 32'd0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 5'd0, 5'd0);
    check("flush_no_x9", {31'd0, stall_a}, 32'd0);
    tick();
    idle(5);

    // LOAD_READY=4 instance: load x3 then consumer x3 -> three stall cycles
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd3);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 5'd13);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("lr4_stall_c%0d", i), {30'd0, stall_b, cmux_b}, 32'h2);
      tick();
    end
    check("lr4_release", {30'd0, stall_b, cmux_b}, 32'h1);
    tick();
    idle(5);

    // reset asserted mid-stall drops the stall at once
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd4);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd4, 5'd0, 5'd14);
    check("midrst_pre", {31'd0, stall_a}, 32'd1);
    arst_n = 1'b0;
    #1;
    check("midrst_drop", {28'd0, stall_a, wif_a, wpc_a, cmux_a}, 32'h7);
`ifdef HAZARD_STALL_PERF_EN
    check("midrst_perf", sc_a, 32'd0);
`endif
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    check("midrst_cleared", {31'd0, stall_a}, 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
